matrix_block_reader: RTL

- Streams the elements of one stored matrix out of the shared matrix BRAM as a valid/ready stream.
- Per request: computes the block base address from the matrix ID, reads metadata word 0, validates the shape, then emits every element in row-major or column-major (transposed) order.
- Front end for all matrix operators; replaces the hand-rolled address loops in each operator.

---
 rtl/matrix_block_reader.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_block_reader.sv
// Streams one stored matrix out of the shared matrix BRAM as a valid/ready
// element stream in row-major or column-major order.
module matrix_block_reader #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int ID_WIDTH   = 3,
  parameter int META_WORDS = 3,
  parameter int DIM_WIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ID_WIDTH-1:0]   matrix_id,
  input  logic                  col_major,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DIM_WIDTH-1:0]  shape_rows,
  output logic [DIM_WIDTH-1:0]  shape_cols,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DIM_WIDTH-1:0]  out_row,
  output logic [DIM_WIDTH-1:0]  out_col,
  output logic                  out_last,
  output logic [3:0]            status,
  output logic                  done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int unsigned MAX_ELEMS = BLOCK_SIZE - META_WORDS;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_META_WAIT, S_STREAM, S_DRAIN,
    S_SUCCESS, S_ERR_ID, S_ERR_EMPTY, S_ERR_FORMAT
  } state_t;

  state_t state, state_next;

  logic [ID_WIDTH-1:0]   id_q;
  logic                  col_major_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, col_addr_q;
  logic [DIM_WIDTH-1:0]  r_q, c_q;
  logic [1:0]            meta_cnt;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [DIM_WIDTH-1:0]  pipe_row [RD_LATENCY];
  logic [DIM_WIDTH-1:0]  pipe_col [RD_LATENCY];
  logic                  pipe_last [RD_LATENCY];
  logic [CNT_W-1:0]      outstanding, fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [DIM_WIDTH-1:0]  fifo_row [FIFO_DEPTH];
  logic [DIM_WIDTH-1:0]  fifo_col [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];

  logic                   issue, ret, pop, meta_done, at_last, credit_ok, can_start;
  logic [DIM_WIDTH-1:0]   meta_rows, meta_cols;
  logic [2*DIM_WIDTH-1:0] area;
  logic [CNT_W:0]         inflight;

  function automatic logic is_term(state_t s);
    return (s == S_SUCCESS) || (s == S_ERR_ID) || (s == S_ERR_EMPTY) || (s == S_ERR_FORMAT);
  endfunction

  assign can_start = (state == S_IDLE) || is_term(state);
  assign meta_rows = mem_rd_data[DATA_WIDTH-1 -: DIM_WIDTH];
  assign meta_cols = mem_rd_data[DATA_WIDTH-1-DIM_WIDTH -: DIM_WIDTH];
  assign area      = (2*DIM_WIDTH)'(meta_rows) * (2*DIM_WIDTH)'(meta_cols);
  assign meta_done = (meta_cnt == 2'(RD_LATENCY - 1));
  assign at_last   = (r_q == shape_rows - DIM_WIDTH'(1)) && (c_q == shape_cols - DIM_WIDTH'(1));
  // Reads in flight plus buffered elements may never exceed the FIFO, so every
  // returning word always has a slot even if the consumer stalls.
  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign credit_ok = inflight < DEPTH_C;
  assign ret       = pipe_v[RD_LATENCY-1];
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state)
      S_IDLE, S_SUCCESS, S_ERR_ID, S_ERR_EMPTY, S_ERR_FORMAT:
        if (start) state_next = S_CHECK;
      S_CHECK:
        if (id_q == '0) state_next = S_ERR_ID;
        else begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = base_q;
          state_next  = S_META_WAIT;
        end
      S_META_WAIT:
        if (meta_done) begin
          if (meta_rows == '0 || meta_cols == '0) state_next = S_ERR_EMPTY;
          else if (32'(area) > 32'(MAX_ELEMS))    state_next = S_ERR_FORMAT;
          else                                    state_next = S_STREAM;
        end
      S_STREAM:
        if (credit_ok) begin
          issue       = 1'b1;
          mem_rd_en   = 1'b1;
          mem_rd_addr = addr_q;
          if (at_last) state_next = S_DRAIN;
        end
      S_DRAIN:
        if (fifo_cnt == '0 && outstanding == '0) state_next = S_SUCCESS;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      S_IDLE:       status = 4'd0;
      S_SUCCESS:    status = 4'd2;
      S_ERR_ID:     status = 4'd4;
      S_ERR_EMPTY:  status = 4'd5;
      S_ERR_FORMAT: status = 4'd7;
      default:      status = 4'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      id_q        <= '0;
      col_major_q <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      col_addr_q  <= '0;
      r_q         <= '0;
      c_q         <= '0;
      meta_cnt    <= '0;
      shape_rows  <= '0;
      shape_cols  <= '0;
    end else begin
      state <= state_next;
      done  <= is_term(state_next) && !is_term(state);
      if (start && can_start) begin
        id_q        <= matrix_id;
        col_major_q <= col_major;
        base_q      <= ADDR_WIDTH'(32'(matrix_id) * 32'(BLOCK_SIZE));
        shape_rows  <= '0;
        shape_cols  <= '0;
      end
      if (state == S_CHECK) meta_cnt <= '0;
      else if (state == S_META_WAIT) meta_cnt <= meta_cnt + 2'd1;
      if (state == S_META_WAIT && meta_done) begin
        shape_rows <= meta_rows;
        shape_cols <= meta_cols;
        addr_q     <= base_q + ADDR_WIDTH'(META_WORDS);
        col_addr_q <= base_q + ADDR_WIDTH'(META_WORDS);
        r_q        <= '0;
        c_q        <= '0;
      end
      // Incremental walk: col-major steps by cols and restarts at the next column head.
      if (issue) begin
        if (!col_major_q) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (c_q == shape_cols - DIM_WIDTH'(1)) begin
            c_q <= '0;
            r_q <= r_q + DIM_WIDTH'(1);
          end else c_q <= c_q + DIM_WIDTH'(1);
        end else if (r_q == shape_rows - DIM_WIDTH'(1)) begin
          r_q        <= '0;
          c_q        <= c_q + DIM_WIDTH'(1);
          addr_q     <= col_addr_q + ADDR_WIDTH'(1);
          col_addr_q <= col_addr_q + ADDR_WIDTH'(1);
        end else begin
          r_q    <= r_q + DIM_WIDTH'(1);
          addr_q <= addr_q + ADDR_WIDTH'(shape_cols);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v      <= '0;
      outstanding <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_row[i]  <= '0;
        pipe_col[i]  <= '0;
        pipe_last[i] <= 1'b0;
      end
    end else begin
      pipe_v[0]    <= issue;
      pipe_row[0]  <= r_q;
      pipe_col[0]  <= c_q;
      pipe_last[0] <= at_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_row[i]  <= pipe_row[i-1];
        pipe_col[i]  <= pipe_col[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(ret);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_row[i]  <= '0;
        fifo_col[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (ret) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_row[wr_ptr]  <= pipe_row[RD_LATENCY-1];
        fifo_col[wr_ptr]  <= pipe_col[RD_LATENCY-1];
        fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(ret) - CNT_W'(pop);
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_row   = out_valid ? fifo_row[rd_ptr]  : '0;
  assign out_col   = out_valid ? fifo_col[rd_ptr]  : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];
endmodule
